apb_master_bridge: RTL and testbench

//   APB requester (initiator) that drives the APB slave memory side of the bus.

---
 rtl/apb_master_bridge.sv | 118 +++++++++++
 tb/tb_apb_master_bridge.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB requester: one command in, one SETUP/ACCESS transfer out, one response back.
// Optional ACCESS timeout is built only when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  Pclk,
    input  logic                  Prst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] Paddr,
    output logic                  Pselx,
    output logic                  Penable,
    output logic                  Pwrite,
    output logic [DATA_WIDTH-1:0] Pwdata,
    input  logic                  Pready,
    input  logic                  Pslverr,
    input  logic [DATA_WIDTH-1:0] Prdata,
    output logic [1:0]            fsm_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0] state;

    // Handshakes: a beat moves on a rising edge where valid and ready are both
    // high; valid and its payload stay stable until then, and ready never
    // depends on valid. cmd_ready is high only in IDLE.
    assign cmd_ready = (state == IDLE);
    assign fsm_state = state;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge Pclk) begin
        if (Prst || state != ACCESS) begin
            tmo_cnt <= '0;
        end else if (!Pready) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // True on the ACCESS cycle whose wait would bring the count to the limit.
    logic tmo_hit;
    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge Pclk) begin
        if (Prst) begin
            state     <= IDLE;
            Pselx     <= 1'b0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        Pwrite  <= cmd_write;
                        Paddr   <= cmd_addr;
                        Pwdata  <= cmd_wdata;
                        Pselx   <= 1'b1;
                        Penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    Penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (Pready) begin
                        rsp_err   <= Pslverr;
                        rsp_rdata <= Pwrite ? '0 : Prdata;
                        rsp_valid <= 1'b1;
                        Pselx     <= 1'b0;
                        Penable   <= 1'b0;
                        state     <= RESP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (tmo_hit) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        Pselx     <= 1'b0;
                        Penable   <= 1'b0;
                        state     <= RESP;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus random
// transfers checked against a memory-level reference model.
module tb_apb_master_bridge;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic psel, penable, pwrite, pready, pslverr;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_fail = 0;

  // slave memory (environment) and reference memory (model)
  logic [31:0] slave_mem [256];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_q [$];

  apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .Pclk(clk), .Prst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Paddr(paddr), .Pselx(psel), .Penable(penable), .Pwrite(pwrite), .Pwdata(pwdata),
    .Pready(pready), .Pslverr(pslverr), .Prdata(prdata), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: expected read data from the memory-level view.
  function automatic logic [31:0] model_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Driver: issues one command (starting at a negedge with the bridge idle),
  // plays a slave with 'waits' wait states, applies 'bp' cycles of response
  // backpressure and reports what it observed. Returns at a negedge one cycle
  // after the response handshake.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int waits, input logic err, input int bp,
                      output int lat, output logic [31:0] rdata, output logic rerr,
                      output int en_cyc, output int sel_cyc, output int hold,
                      output int viol, output logic back);
    int c, acc;
    logic hs, done;
    lat = -1; rdata = 'x; rerr = 'x; en_cyc = 0; sel_cyc = 0; hold = 0; viol = 0;
    back = 1'b0; c = 0; acc = 0; hs = 1'b0; done = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    rsp_ready = 1'b0; pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
    @(posedge clk);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      c++;
      if (hs) begin
        back = cmd_ready && !rsp_valid;
        done = 1'b1;
      end else begin
        // junk command while busy must be ignored
        cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        if (cmd_ready) viol++;
        if (psel) begin
          sel_cyc++;
          if (paddr !== a || pwrite !== w || pwdata !== d) viol++;
        end
        if (penable) begin
          en_cyc++;
          if (!psel) viol++;
        end
        if (psel && penable) begin
          if (acc == waits) begin
            pready = 1'b1; pslverr = err;
            prdata = w ? $urandom : slave_mem[a[7:0]];
            if (w && !err) slave_mem[a[7:0]] = d;
          end else begin
            pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
          end
          acc++;
        end else begin
          pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
        end
        if (rsp_valid) begin
          if (lat < 0) begin
            lat = c; rdata = rsp_rdata; rerr = rsp_err;
          end else if (rsp_rdata !== rdata || rsp_err !== rerr) viol++;
          hold++;
          if (hold > bp) begin
            rsp_ready = 1'b1; cmd_valid = 1'b0; hs = 1'b1;
          end else rsp_ready = 1'b0;
        end else rsp_ready = 1'($urandom);
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset(3);
    n_checks++; if (psel !== 1'b0) begin n_fail++; $display("FAIL reset_psel: got %b want 0", psel); end
    n_checks++; if (penable !== 1'b0) begin n_fail++; $display("FAIL reset_penable: got %b want 0", penable); end
    n_checks++; if (pwrite !== 1'b0) begin n_fail++; $display("FAIL reset_pwrite: got %b want 0", pwrite); end
    n_checks++; if (paddr !== 32'h0) begin n_fail++; $display("FAIL reset_paddr: got %h want 0", paddr); end
    n_checks++; if (pwdata !== 32'h0) begin n_fail++; $display("FAIL reset_pwdata: got %h want 0", pwdata); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write;
    int lat, en, sel, hold, viol; logic [31:0] rd; logic er, back;
    ref_mem[32'h4] = 32'hDEADBEEF;
    xfer(1'b1, 32'h4, 32'hDEADBEEF, 0, 1'b0, 0, lat, rd, er, en, sel, hold, viol, back);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL write_latency: got %0d want 3", lat); end
    n_checks++; if (sel !== 2) begin n_fail++; $display("FAIL write_psel_cycles: got %0d want 2", sel); end
    n_checks++; if (en !== 1) begin n_fail++; $display("FAIL write_penable_cycles: got %0d want 1", en); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL write_rdata: got %h want 0", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL write_err: got %b want 0", er); end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL write_protocol: got %0d violations want 0", viol); end
    n_checks++; if (back !== 1'b1) begin n_fail++; $display("FAIL write_cmd_ready_back: got %b want 1", back); end
  endtask

  task automatic test_read_back;
    int lat, en, sel, hold, viol; logic [31:0] rd, exp; logic er, back;
    exp_q.push_back(model_read(32'h4));
    xfer(1'b0, 32'h4, 32'h0, 0, 1'b0, 0, lat, rd, er, en, sel, hold, viol, back);
    exp = exp_q.pop_front();
    n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL readback_rdata: got %h want %h", rd, exp); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL readback_err: got %b want 0", er); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL readback_latency: got %0d want 3", lat); end
  endtask

  task automatic test_wait_states;
    int lat, en, sel, hold, viol; logic [31:0] rd; logic er, back;
    ref_mem[32'h40] = 32'h1234_5678;
    xfer(1'b1, 32'h40, 32'h1234_5678, 3, 1'b0, 0, lat, rd, er, en, sel, hold, viol, back);
    n_checks++; if (en !== 4) begin n_fail++; $display("FAIL wait_penable_cycles: got %0d want 4", en); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL wait_latency: got %0d want 6", lat); end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL wait_stable: got %0d violations want 0", viol); end
  endtask

  task automatic test_error_backpressure;
    int lat, en, sel, hold, viol; logic [31:0] rd, exp; logic er, back;
    exp_q.push_back(model_read(32'h40));
    xfer(1'b0, 32'h40, 32'h0, 0, 1'b1, 5, lat, rd, er, en, sel, hold, viol, back);
    exp = exp_q.pop_front();
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_bp_err: got %b want 1", er); end
    n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL err_bp_rdata: got %h want %h", rd, exp); end
    n_checks++; if (hold !== 6) begin n_fail++; $display("FAIL err_bp_hold: got %0d want 6", hold); end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL err_bp_protocol: got %0d violations want 0", viol); end
    n_checks++; if (back !== 1'b1) begin n_fail++; $display("FAIL err_bp_cmd_ready_back: got %b want 1", back); end
  endtask

  task automatic test_reset_mid;
    int seen;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80; cmd_wdata = 32'hA5A5_A5A5;
    rsp_ready = 1'b1; pready = 1'b0;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (penable !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_access: got %b want 1", penable); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_checks++; if (psel !== 1'b0) begin n_fail++; $display("FAIL rstmid_psel: got %b want 0", psel); end
    n_checks++; if (penable !== 1'b0) begin n_fail++; $display("FAIL rstmid_penable: got %b want 0", penable); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++; if (paddr !== 32'h0) begin n_fail++; $display("FAIL rstmid_paddr: got %h want 0", paddr); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      pready = 1'($urandom);
      @(negedge clk);
      if (rsp_valid || psel) seen++;
    end
    pready = 1'b0; rsp_ready = 1'b0;
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_response: got %0d busy cycles want 0", seen); end
  endtask

  task automatic test_random;
    int lat, en, sel, hold, viol, waits, bp; logic [31:0] rd, a, d, exp; logic er, back, w, e;
    for (int k = 0; k < 24; k++) begin
      w = 1'($urandom); a = {22'h0, 8'($urandom_range(0, 63) * 4), 2'b00} & 32'hFC;
      d = $urandom; waits = $urandom_range(0, 5); bp = $urandom_range(0, 3);
      e = ($urandom_range(0, 3) == 0);
      if (w) begin
        if (!e) ref_mem[a] = d;
        exp_q.push_back(32'h0);
      end else exp_q.push_back(model_read(a));
      xfer(w, a, d, waits, e, bp, lat, rd, er, en, sel, hold, viol, back);
      exp = exp_q.pop_front();
      n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL rand%0d_rdata: got %h want %h", k, rd, exp); end
      n_checks++; if (er !== e) begin n_fail++; $display("FAIL rand%0d_err: got %b want %b", k, er, e); end
      n_checks++; if (lat !== 3 + waits) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", k, lat, 3 + waits); end
      n_checks++; if (en !== waits + 1) begin n_fail++; $display("FAIL rand%0d_penable: got %0d want %0d", k, en, waits + 1); end
      n_checks++; if (hold !== bp + 1) begin n_fail++; $display("FAIL rand%0d_hold: got %0d want %0d", k, hold, bp + 1); end
      n_checks++; if (viol !== 0 || back !== 1'b1) begin n_fail++; $display("FAIL rand%0d_protocol: got %0d/%b want 0/1", k, viol, back); end
    end
  endtask

  task automatic test_idle_hold;
    int lat, en, sel, hold, viol, bad; logic [31:0] rd; logic er, back;
    ref_mem[32'hC0] = 32'hCAFE_F00D;
    xfer(1'b1, 32'hC0, 32'hCAFE_F00D, 1, 1'b0, 0, lat, rd, er, en, sel, hold, viol, back);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = 1'($urandom);
      pready = 1'($urandom); rsp_ready = 1'($urandom);
      @(negedge clk);
      if (paddr !== 32'hC0 || pwdata !== 32'hCAFE_F00D || pwrite !== 1'b1 || psel || rsp_valid) bad++;
    end
    pready = 1'b0; rsp_ready = 1'b0;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL idle_hold: got %0d changed cycles want 0", bad); end
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    int lat, en, sel, hold, viol; logic [31:0] rd, exp; logic er, back;
    xfer(1'b0, 32'h40, 32'h0, 1000, 1'b0, 0, lat, rd, er, en, sel, hold, viol, back);
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL timeout_latency: got %0d want 18", lat); end
    n_checks++; if (en !== 16) begin n_fail++; $display("FAIL timeout_penable: got %0d want 16", en); end
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", er); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL timeout_rdata: got %h want 0", rd); end
    exp = model_read(32'h40);
    xfer(1'b0, 32'h40, 32'h0, 15, 1'b0, 0, lat, rd, er, en, sel, hold, viol, back);
    n_checks++; if (er !== 1'b0 || rd !== exp) begin n_fail++; $display("FAIL timeout_ready_wins: got %b/%h want 0/%h", er, rd, exp); end
  endtask
`else
  task automatic test_long_wait;
    int lat, en, sel, hold, viol; logic [31:0] rd, exp; logic er, back;
    exp = model_read(32'h40);
    xfer(1'b0, 32'h40, 32'h0, 30, 1'b0, 0, lat, rd, er, en, sel, hold, viol, back);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL long_wait_latency: got %0d want 33", lat); end
    n_checks++; if (er !== 1'b0 || rd !== exp) begin n_fail++; $display("FAIL long_wait_rsp: got %b/%h want 0/%h", er, rd, exp); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) slave_mem[i] = 32'h0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = '0; rst = 1'b1;
    test_reset();
    test_write();
    test_read_back();
    test_wait_states();
    test_error_backpressure();
    test_reset_mid();
    test_random();
    test_idle_hold();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
